// File: rtl/tcam_match_sequencer_pkg.sv
// Shared definitions for the TCAM match sequencer.
//   state_t : sequencer FSM encoding (IDLE / SCAN / DONE)
//   DEPTH   : number of TCAM rows, which is also the match-vector width
//   ADDR_W  : row-address width
//   CNT_W   : match-count width; it holds 0..DEPTH
package tcam_seq_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tcam_match_sequencer_pe.sv
// 64-to-6 priority encoder. The highest set index wins.
//   in_vec   : 64-bit request vector
//   out_addr : index of the highest set bit, or 0 when in_vec is zero
//   out_any  : at least one bit of in_vec is set
module priority_encoder_64x6
  import tcam_seq_pkg::*;
(
  input  logic [DEPTH-1:0]  in_vec,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_any
);

  // The loop scans upward, so a later (higher) set bit overwrites an earlier one.
  always_comb begin
    out_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_vec[i]) begin
        out_addr = ADDR_W'(i);
      end
    end
  end

  assign out_any = |in_vec;

endmodule

// File: rtl/tcam_match_sequencer.sv
// Accepts one TCAM search result and returns every matching row address,
// one per handshake, highest index first. It supports first-match-only mode
// and mid-search abort, and ends each search with a one-cycle done pulse.
//   in_clk, in_rst_n                  : clock, async active-low reset
//   in_valid/in_ready/in_match_vec    : search-result input handshake
//   in_first_only                     : sampled with the vector; return top match only
//   in_abort                          : drop the remaining matches (SCAN only)
//   out_valid/out_ready/out_addr      : matching-row output handshake
//   out_done                          : end-of-search pulse
//   out_miss/out_aborted/out_count    : search summary, qualified by out_done
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a search vector; in_ready=1
// SCAN  | presenting PE(pend) on out_addr until pend is empty/first/abort
// DONE  | one-cycle out_done pulse carrying count/miss/aborted
module tcam_match_sequencer
  import tcam_seq_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEPTH-1:0]  in_match_vec,
  input  logic              in_first_only,
  input  logic              in_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_done,
  output logic              out_miss,
  output logic              out_aborted,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   pend;
  logic               first_q;
  logic [CNT_W-1:0]   cnt;
  logic               miss_q;
  logic               abort_q;

  logic [ADDR_W-1:0]  pe_addr;
  logic               pe_any;
  logic [DEPTH-1:0]   clr_mask;
  logic [DEPTH-1:0]   pend_cleared;
  logic               accept;
  logic               hs;

  priority_encoder_64x6 u_pe (
    .in_vec   (pend),
    .out_addr (pe_addr),
    .out_any  (pe_any)
  );

  assign clr_mask     = DEPTH'(1) << pe_addr;
  assign pend_cleared = pend & ~clr_mask;

  assign accept = (state == ST_IDLE) && in_valid;
  // An abort in the same cycle takes priority over the handshake, so that
  // cycle neither counts nor clears a match.
  assign hs     = (state == ST_SCAN) && out_ready && !in_abort;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_addr    = '0;
    out_done    = 1'b0;
    out_miss    = 1'b0;
    out_aborted = 1'b0;
    out_count   = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (|in_match_vec) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        out_valid = 1'b1;
        out_addr  = pe_addr;
        if (in_abort) begin
          state_nxt = ST_DONE;
        end else if (out_ready && (first_q || !(|pend_cleared))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_done    = 1'b1;
        out_count   = cnt;
        out_miss    = miss_q;
        out_aborted = abort_q;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pend    <= '0;
      first_q <= 1'b0;
      cnt     <= '0;
      miss_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (accept) begin
        pend    <= in_match_vec;
        first_q <= in_first_only;
        cnt     <= '0;
        abort_q <= 1'b0;
        miss_q  <= ~(|in_match_vec);
      end else if ((state == ST_SCAN) && in_abort) begin
        pend    <= '0;
        abort_q <= 1'b1;
      end else if (hs) begin
        pend <= pend_cleared;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

  // pe_any is not needed by the control path: SCAN is only entered with a
  // non-empty vector, and it is left as soon as the vector empties.
  logic unused_pe_any;
  assign unused_pe_any = pe_any;

endmodule

// File: tb/tb_tcam_match_sequencer.sv
module tb_tcam_match_sequencer;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_match_vec;
  logic        in_first_only;
  logic        in_abort;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_addr;
  logic        out_done;
  logic        out_miss;
  logic        out_aborted;
  logic [6:0]  out_count;

  int errors = 0;
  int checks = 0;

  tcam_match_sequencer dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_match_vec  (in_match_vec),
    .in_first_only (in_first_only),
    .in_abort      (in_abort),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_done      (out_done),
    .out_miss      (out_miss),
    .out_aborted   (out_aborted),
    .out_count     (out_count)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk_scan(input string tag, input logic [5:0] addr);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_addr"},  64'(out_addr),  64'(addr));
    chk({tag, "_ready"}, 64'(in_ready),  64'd0);
    chk({tag, "_done"},  64'(out_done),  64'd0);
  endtask

  task automatic chk_done(input string tag, input logic [6:0] count,
                          input logic miss, input logic aborted);
    chk({tag, "_done"},    64'(out_done),    64'd1);
    chk({tag, "_count"},   64'(out_count),   64'(count));
    chk({tag, "_miss"},    64'(out_miss),    64'(miss));
    chk({tag, "_aborted"}, 64'(out_aborted), 64'(aborted));
    chk({tag, "_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_ready"},   64'(in_ready),    64'd0);
  endtask

  task automatic send(input logic [63:0] vec, input logic first);
    in_valid      = 1'b1;
    in_match_vec  = vec;
    in_first_only = first;
    tick();
    in_valid      = 1'b0;
    in_match_vec  = '0;
    in_first_only = 1'b0;
  endtask

  initial begin
    in_rst_n      = 1'b0;
    in_valid      = 1'b0;
    in_match_vec  = '0;
    in_first_only = 1'b0;
    in_abort      = 1'b0;
    out_ready     = 1'b0;
    #12;
    chk("rst_valid",   64'(out_valid),   64'd0);
    chk("rst_done",    64'(out_done),    64'd0);
    chk("rst_addr",    64'(out_addr),    64'd0);
    chk("rst_count",   64'(out_count),   64'd0);
    chk("rst_miss",    64'(out_miss),    64'd0);
    chk("rst_aborted", 64'(out_aborted), 64'd0);
    tick();
    in_rst_n = 1'b1;
    tick();
    chk("idle_ready", 64'(in_ready), 64'd1);

    // Single match
    out_ready = 1'b1;
    send(64'h0000_0000_0000_0010, 1'b0);
    chk_scan("single", 6'd4);
    tick();
    chk_done("single_end", 7'd1, 1'b0, 1'b0);
    tick();
    chk("single_idle", 64'(in_ready), 64'd1);
    chk("single_idle_addr", 64'(out_addr), 64'd0);

    // Multi-match at full rate
    send(64'h8000_0000_0000_0005, 1'b0);
    chk_scan("multi0", 6'd63);
    tick();
    chk_scan("multi1", 6'd2);
    tick();
    chk_scan("multi2", 6'd0);
    tick();
    chk_done("multi_end", 7'd3, 1'b0, 1'b0);
    tick();

    // Backpressure: three cycles with out_ready low
    out_ready = 1'b0;
    send(64'h0000_0001_0000_0100, 1'b0);
    chk_scan("bp_hold0", 6'd32);
    tick();
    chk_scan("bp_hold1", 6'd32);
    tick();
    chk_scan("bp_hold2", 6'd32);
    out_ready = 1'b1;
    tick();
    chk_scan("bp_next", 6'd8);
    tick();
    chk_done("bp_end", 7'd2, 1'b0, 1'b0);
    tick();

    // First-only mode
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk_scan("first", 6'd63);
    tick();
    chk_done("first_end", 7'd1, 1'b0, 1'b0);
    tick();

    // Miss: DONE directly after the accept cycle, no out_valid
    send(64'h0, 1'b0);
    chk_done("miss_end", 7'd0, 1'b1, 1'b0);
    tick();
    chk("miss_idle", 64'(in_ready), 64'd1);

    // Abort with a simultaneous handshake on row 10
    send(64'h0000_0000_0000_0F00, 1'b0);
    chk_scan("abort0", 6'd11);
    tick();
    chk_scan("abort1", 6'd10);
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    chk_done("abort_end", 7'd1, 1'b0, 1'b1);
    tick();
    send(64'h0000_0000_0000_0002, 1'b0);
    chk_scan("post_abort", 6'd1);
    tick();
    chk_done("post_abort_end", 7'd1, 1'b0, 1'b0);
    tick();

    // Async reset in the middle of a scan
    send(64'h0000_0000_0000_001F, 1'b0);
    chk_scan("rst_scan0", 6'd4);
    tick();
    chk_scan("rst_scan1", 6'd3);
    tick();
    chk_scan("rst_scan2", 6'd2);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_done",  64'(out_done),  64'd0);
    tick();
    tick();
    in_rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_done",  64'(out_done), 64'd0);
    send(64'h0000_0000_0000_0001, 1'b0);
    chk_scan("fresh", 6'd0);
    tick();
    chk_done("fresh_end", 7'd1, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
